// File: rtl/mul_seq_shift_add.sv
// -----------------------------------------------------------------------------
// mul_seq_shift_add
//   Sequential shift-add multiplier, q = a * b. It processes one multiplier bit
//   per ctl_clk cycle and uses the same trigger/ready/done handshake as the
//   divider, so a single sequencer can drive both. Operands can be unsigned or
//   two's complement. The product can be read as Q-format fixed point: the
//   full product is shifted right by FIXED_POINT before q is taken.
//
//   Ports
//     ctl_clk     in   clock, rising edge
//     reset       in   asynchronous, active-low reset
//     a, b        in   multiplicand / multiplier, sampled with trigger
//     signed_cal  in   1 = two's-complement operands/result, sampled with trigger
//     trigger     in   start request, accepted only while ready=1
//     q           out  result, updated with done and held until the next done
//     ovf         out  result did not fit in C_WIDTH bits, qualified like q
//     ready       out  idle; a trigger in this cycle is accepted
//     done        out  one-cycle pulse; q/ovf are updated in the same cycle
//
//   Latency does not depend on the data. If trigger is accepted at edge N,
//   done is high for the cycle that follows edge N+C_WIDTH+1.
// -----------------------------------------------------------------------------
module mul_seq_shift_add #(
   parameter int C_WIDTH     = 32,
   parameter int FIXED_POINT = 0
) (
   input  logic               ctl_clk,
   input  logic               reset,
   input  logic [C_WIDTH-1:0] a,
   input  logic [C_WIDTH-1:0] b,
   input  logic               signed_cal,
   input  logic               trigger,
   output logic [C_WIDTH-1:0] q,
   output logic               ovf,
   output logic               ready,
   output logic               done
);

   localparam int PW = 2 * C_WIDTH;
   localparam int CW = (C_WIDTH > 1) ? $clog2(C_WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [C_WIDTH-1:0] mcand_q, mcand_d;   // |a|
   logic [C_WIDTH-1:0] mplier_q, mplier_d; // |b|, shifted right once per iteration
   logic               neg_q, neg_d;       // result must be negated
   logic               sgn_q, sgn_d;       // operation is signed (selects the ovf rule)
   logic [PW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [C_WIDTH-1:0] res_q, res_d;
   logic               ovf_q, ovf_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;

   logic [C_WIDTH-1:0] abs_a, abs_b;
   logic [PW-1:0]      prod;
   logic signed [PW-1:0] hi_s;
   logic [PW-1:0]      hi_u;
   logic               ovf_s, ovf_u;

   always_comb begin
      abs_a = (signed_cal && a[C_WIDTH-1]) ? -a : a;
      abs_b = (signed_cal && b[C_WIDTH-1]) ? -b : b;

      // Full signed/unsigned product, taken from the magnitude accumulator.
      prod = neg_q ? -acc_q : acc_q;

      // Signed: the bits from q's MSB up to the top of the product must all
      // hold the same value. After an arithmetic shift that leaves all zeros
      // or all ones.
      hi_s  = $signed(prod) >>> (C_WIDTH - 1 + FIXED_POINT);
      ovf_s = !((hi_s == '0) || (hi_s == '1));
      // Unsigned: every bit above q's field must be zero.
      hi_u  = prod >> (C_WIDTH + FIXED_POINT);
      ovf_u = |hi_u;

      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      sgn_d    = sgn_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      ovf_d    = ovf_q;
      ready_d  = ready_q;
      done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (trigger) begin
               mcand_d  = abs_a;
               mplier_d = abs_b;
               neg_d    = signed_cal & (a[C_WIDTH-1] ^ b[C_WIDTH-1]);
               sgn_d    = signed_cal;
               acc_d    = '0;
               cnt_d    = '0;
               ready_d  = 1'b0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            if (mplier_q[0])
               acc_d = acc_q + ({{C_WIDTH{1'b0}}, mcand_q} << cnt_q);
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(C_WIDTH - 1))
               state_d = S_FINISH;
         end
         S_FINISH: begin
            // Taking this bit slice truncates toward negative infinity, for
            // both signed and unsigned results.
            res_d   = prod[C_WIDTH-1+FIXED_POINT -: C_WIDTH];
            ovf_d   = sgn_q ? ovf_s : ovf_u;
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ctl_clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         sgn_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         sgn_q    <= sgn_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   assign q     = res_q;
   assign ovf   = ovf_q;
   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_shift_add
//   Two multipliers share the same stimulus: an integer one (FIXED_POINT=0)
//   and a Q4 one (FIXED_POINT=4), both with C_WIDTH=8. Each result is
//   compared with an arithmetic reference model, and the handshake timing is
//   checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_mul_seq_shift_add;

   localparam int W   = 8;
   localparam int FP1 = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         sc    = 1'b0;
   logic         trig  = 1'b0;

   logic [W-1:0] q0, q1;
   logic         ovf0, ovf1, rdy0, rdy1, dn0, dn1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mul_seq_shift_add #(.C_WIDTH(W), .FIXED_POINT(0)) u_dut0 (
      .ctl_clk(clk), .reset(rst_n), .a(a), .b(b), .signed_cal(sc), .trigger(trig),
      .q(q0), .ovf(ovf0), .ready(rdy0), .done(dn0));

   mul_seq_shift_add #(.C_WIDTH(W), .FIXED_POINT(FP1)) u_dut1 (
      .ctl_clk(clk), .reset(rst_n), .a(a), .b(b), .signed_cal(sc), .trigger(trig),
      .q(q1), .ovf(ovf1), .ready(rdy1), .done(dn1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer product, floor-shifted, then a range check.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input int fp,
                                 output logic [W-1:0] qe, output logic oe);
      longint sx, sy, r, lim;
      sx  = s ? longint'($signed(x)) : longint'(x);
      sy  = s ? longint'($signed(y)) : longint'(y);
      r   = (sx * sy) >>> fp;
      lim = longint'(1) << (W - 1);
      qe  = r[W-1:0];
      oe  = s ? ((r < -lim) || (r >= lim)) : (r >= 2 * lim);
   endfunction

   // Present the operands with a one-cycle trigger. Returns just after the
   // accepting edge.
   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      a = x; b = y; sc = s; trig = 1'b1;
      @(posedge clk); #1;
      trig = 1'b0;
   endtask

   // Follow an accepted operation up to its done cycle. If retrig_at > 0, a
   // disturbing trigger with different operands is pulsed during CALC.
   task automatic finish_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                            input int retrig_at, input string tag);
      logic [W-1:0] e0, e1;
      logic         o0, o1;
      model(x, y, s, 0, e0, o0);
      model(x, y, s, FP1, e1, o1);
      for (int k = 1; k <= W + 1; k++) begin
         @(posedge clk); #1;
         trig = 1'b0;
         chk({tag, "/done_ready"}, {28'd0, dn0, rdy0, dn1, rdy1},
             (k == W + 1) ? 32'hf : 32'h0);
         if (k == retrig_at) begin
            a = ~x; b = y + 8'd1; sc = ~s; trig = 1'b1;
         end
      end
      chk({tag, "/q0"},   {24'd0, q0}, {24'd0, e0});
      chk({tag, "/ovf0"}, {31'd0, ovf0}, {31'd0, o0});
      chk({tag, "/q1"},   {24'd0, q1}, {24'd0, e1});
      chk({tag, "/ovf1"}, {31'd0, ovf1}, {31'd0, o1});
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge clk); #1;
      chk({tag, "/idle"}, {28'd0, dn0, rdy0, dn1, rdy1}, 32'h5);
   endtask

   logic [W-1:0] da [7] = '{8'h0f, 8'h05, 8'h80, 8'hff, 8'h00, 8'h18, 8'h7f};
   logic [W-1:0] db [7] = '{8'h05, 8'hfd, 8'h80, 8'hff, 8'hff, 8'h28, 8'h81};
   logic         ds [7] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};

   initial begin
      logic [W-1:0] rx, ry;
      logic         rs;

      // Reset state
      #12;
      chk("rst/q0",   {24'd0, q0}, 32'h0);
      chk("rst/q1",   {24'd0, q1}, 32'h0);
      chk("rst/ctl",  {26'd0, ovf0, ovf1, dn0, rdy0, dn1, rdy1}, 32'h5);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed operand patterns
      for (int i = 0; i < 7; i++) begin
         launch(da[i], db[i], ds[i]);
         finish_op(da[i], db[i], ds[i], 0, $sformatf("dir%0d", i));
         idle_cycle($sformatf("dir%0d", i));
      end

      // A trigger during CALC with new operands must be ignored
      launch(8'h23, 8'h06, 1'b0);
      finish_op(8'h23, 8'h06, 1'b0, 3, "retrig");
      idle_cycle("retrig");

      // A trigger in the done cycle is accepted back-to-back
      launch(8'h11, 8'h0c, 1'b0);
      finish_op(8'h11, 8'h0c, 1'b0, 0, "b2b_a");
      launch(8'hf6, 8'h07, 1'b1);
      finish_op(8'hf6, 8'h07, 1'b1, 0, "b2b_b");
      idle_cycle("b2b");

      // Reset during CALC aborts the operation at once, with no late done
      launch(8'h37, 8'h11, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst/ctl", {28'd0, dn0, rdy0, dn1, rdy1}, 32'h5);
      chk("midrst/q0",  {24'd0, q0}, 32'h0);
      chk("midrst/q1",  {24'd0, q1}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < W + 4; k++) idle_cycle("midrst");

      // Random operands and signedness
      for (int i = 0; i < 40; i++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         rs = 1'($urandom_range(0, 1));
         launch(rx, ry, rs);
         finish_op(rx, ry, rs, (i % 4 == 0) ? 5 : 0, $sformatf("rnd%0d", i));
         idle_cycle($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
